// File: rtl/adder_mc_pkg.sv
// Shared definitions for the multi-cycle adder family: FSM state encodings and
// a constant-evaluable clog2 used to size slice counters.
package adder_mc_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_mc_slice.sv
// Combinational D-bit adder slice: sum, carry out of the top bit, and signed
// overflow (carry into top bit XOR carry out of top bit).
module adder_slice #(
    parameter int D = 4
) (
    input  logic [D-1:0] a,
    input  logic [D-1:0] b,
    input  logic         ci,
    output logic [D-1:0] s,
    output logic         co,
    output logic         ov
);

    logic [D:0] total;
    logic       carry_into_top;

    always_comb begin
        total          = {1'b0, a} + {1'b0, b} + {{D{1'b0}}, ci};
        s              = total[D-1:0];
        co             = total[D];
        // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out directly
        carry_into_top = a[D-1] ^ b[D-1] ^ total[D-1];
        ov             = carry_into_top ^ total[D];
    end

endmodule

// File: rtl/adder_mc.sv
// Multi-cycle W-bit adder/subtractor: one D-bit slice per clock, LSB first,
// with a registered carry between slices and a Start/Busy/Done handshake.
module adder_mc
    import adder_mc_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Ci,
    input  logic         Sub,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] S,
    output logic         Co,
    output logic         Ov
);

    localparam int N  = W / D;
    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          carry_reg;
    logic [W-1:0]  sum_reg;
    logic [W-1:0]  s_reg;
    logic          co_reg;
    logic          ov_reg;

    logic [D-1:0]  a_slices [N];
    logic [D-1:0]  b_slices [N];
    logic [D-1:0]  a_cur;
    logic [D-1:0]  b_cur;
    logic [D-1:0]  slice_s;
    logic          slice_co;
    logic          slice_ov;
    logic [W-1:0]  sum_next;

    // The working sum with slice cnt replaced by the current slice result
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign a_slices[gi]          = a_reg[gi*D +: D];
            assign b_slices[gi]          = b_reg[gi*D +: D];
            assign sum_next[gi*D +: D]   = (cnt_reg == CW'(gi)) ? slice_s : sum_reg[gi*D +: D];
        end
    endgenerate

    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_reg == CW'(i)) begin
                a_cur = a_slices[i];
                b_cur = b_slices[i];
            end
        end
    end

    adder_slice #(.D(D)) u_slice (
        .a  (a_cur),
        .b  (b_cur),
        .ci (carry_reg),
        .s  (slice_s),
        .co (slice_co),
        .ov (slice_ov)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            s_reg     <= '0;
            co_reg    <= 1'b0;
            ov_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= slice_co;
                    if (cnt_reg == CNT_LAST) begin
                        s_reg     <= sum_next;
                        co_reg    <= slice_co;
                        ov_reg    <= slice_ov;
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation
                    if (Start) begin
                        a_reg     <= A;
                        b_reg     <= Sub ? ~B : B;
                        carry_reg <= Sub | Ci;
                        cnt_reg   <= '0;
                        state_reg <= ST_RUN;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign Busy = (state_reg == ST_RUN);
    assign Done = (state_reg == ST_DONE);
    assign S    = s_reg;
    assign Co   = co_reg;
    assign Ov   = ov_reg;

endmodule
